// File: rtl/gray_counter.sv
// gray_counter: free-running N-bit counter with registered Gray, binary and wrap outputs
module gray_counter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rstn,
  output logic [N-1:0] out,
  output logic [N-1:0] bin,
  output logic         wrap
);
  logic [N-1:0] nxt;
  assign nxt = bin + 1'b1;
  // rstn is active-high despite its name
  always_ff @(posedge clk or posedge rstn)
    if (rstn) begin
      bin  <= '0;
      out  <= '0;
      wrap <= 1'b0;
    end else begin
      bin  <= nxt;
      out  <= nxt ^ (nxt >> 1);
      wrap <= &bin;
    end
endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed checks of gray_counter at N=4 and N=3 run side by side
module tb_gray_counter;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic [3:0] out4, bin4;
  logic [2:0] out3, bin3;
  logic wrap4, wrap3;
  int n_checks = 0;
  int n_fail = 0;
  logic [3:0] g4 [20] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC, 4'hD, 4'hF,
                          4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0, 4'h1, 4'h3, 4'h2, 4'h6};
  logic [2:0] g3 [9] = '{3'h1, 3'h3, 3'h2, 3'h6, 3'h7, 3'h5, 3'h4, 3'h0, 3'h1};
  logic [3:0] prev4;
  logic [2:0] prev3;

  always #5 clk = ~clk;

  gray_counter #(.N(4)) dut4 (.clk(clk), .rstn(rstn), .out(out4), .bin(bin4), .wrap(wrap4));
  gray_counter #(.N(3)) dut3 (.clk(clk), .rstn(rstn), .out(out3), .bin(bin3), .wrap(wrap3));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_out4", 32'(out4), 32'h0);
      check("rst_bin4", 32'(bin4), 32'h0);
      check("rst_wrap4", 32'(wrap4), 32'h0);
      check("rst_out3", 32'(out3), 32'h0);
      check("rst_wrap3", 32'(wrap3), 32'h0);
    end
    rstn = 1'b0;
    prev4 = 4'h0;
    prev3 = 3'h0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("out4[%0d]", i), 32'(out4), 32'(g4[i]));
      check($sformatf("bin4[%0d]", i), 32'(bin4), 32'((i + 1) % 16));
      check($sformatf("wrap4[%0d]", i), 32'(wrap4), (i == 15) ? 32'h1 : 32'h0);
      check($sformatf("ham4[%0d]", i), 32'($countones(out4 ^ prev4)), 32'h1);
      prev4 = out4;
      if (i < 9) begin
        check($sformatf("out3[%0d]", i), 32'(out3), 32'(g3[i]));
        check($sformatf("bin3[%0d]", i), 32'(bin3), 32'((i + 1) % 8));
        check($sformatf("wrap3[%0d]", i), 32'(wrap3), (i == 7) ? 32'h1 : 32'h0);
        check($sformatf("ham3[%0d]", i), 32'($countones(out3 ^ prev3)), 32'h1);
        prev3 = out3;
      end
    end
    @(negedge clk);
    check("pre_async_out4", 32'(out4), 32'h7);
    check("pre_async_bin4", 32'(bin4), 32'h5);
    #2 rstn = 1'b1;
    #1;
    check("async_out4", 32'(out4), 32'h0);
    check("async_bin4", 32'(bin4), 32'h0);
    check("async_wrap4", 32'(wrap4), 32'h0);
    check("async_out3", 32'(out3), 32'h0);
    @(negedge clk);
    check("hold_out4", 32'(out4), 32'h0);
    rstn = 1'b0;
    @(negedge clk);
    check("restart_out4", 32'(out4), 32'h1);
    check("restart_bin4", 32'(bin4), 32'h1);
    check("restart_wrap4", 32'(wrap4), 32'h0);
    check("restart_out3", 32'(out3), 32'h1);
    check("restart_bin3", 32'(bin3), 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 The module SHALL have parameter N, default 4, meaning counter width in bits; legal range 2..32.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rstn, input, 1 bit: reset, asynchronous and active-high; the name is kept for codebase consistency, and rstn=1 holds the block in reset.
REQ-004 The module SHALL have port out, output, N bits: the registered Gray-code count.
REQ-005 The module SHALL have port bin, output, N bits: the registered binary count underlying out.
REQ-006 The module SHALL have port wrap, output, 1 bit: a registered one-cycle pulse on the edge where the count returns to 0.
REQ-007 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.

Function
REQ-008 The module SHALL hold an N-bit binary state register bin.
REQ-009 On each rising clk edge with rstn=0, bin SHALL increment by 1 modulo 2^N.
REQ-010 The increment SHALL wrap 2^N-1 -> 0 with no saturation and no stall.
REQ-011 out SHALL be a register loaded on the same edge as bin with the Gray encoding of the next bin value: next_out = next_bin XOR (next_bin >> 1).
REQ-012 Therefore out == bin ^ (bin >> 1) SHALL hold in every cycle, with zero cycles of latency between bin and out.
REQ-013 Between consecutive clock edges outside reset, out SHALL change in exactly one bit position, including across the wrap 2^N-1 -> 0.
REQ-014 For N=4 the out sequence from reset SHALL be 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8, then 0 and repeating.
REQ-015 At the wrap, out SHALL go from 2^(N-1) (MSB only) to 0.
REQ-016 wrap SHALL be 1 for exactly the one cycle following the edge on which bin goes 2^N-1 -> 0, and 0 otherwise.
REQ-017 The counter SHALL be free-running: there is no enable, load or direction control.

Reset
REQ-018 While rstn=1, out, bin and wrap SHALL be 0, regardless of clk.
REQ-019 Assertion of rstn SHALL clear all registers immediately (asynchronously) without waiting for a clk edge, including mid-count.
REQ-020 After rstn falls, the first rising clk edge with rstn=0 sampled SHALL move out from 0 to 1 and bin from 0 to 1.
REQ-021 No partial or extra count SHALL occur at reset release.
REQ-022 Deassertion of rstn SHALL be treated as synchronous to clk by the integrator; the block adds no reset synchronizer.

Verification
REQ-023 Scenario: rstn=1 for 2 clk cycles -> out=0x0, bin=0, wrap=0 throughout.
REQ-024 Scenario: release rstn, run 20 edges with N=4 -> out follows 1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0,1,3,2,6.
REQ-025 Scenario: run 20 edges with N=4 -> wrap=1 only in the cycle where out=0 after 8.
REQ-026 Scenario: over 2^N+1 edges, check the Hamming distance between successive out values -> exactly 1 every time; also out == bin^(bin>>1) every cycle.
REQ-027 Scenario: assert rstn asynchronously between edges while out=0x7 -> out, bin and wrap are 0 before the next edge; after release the count restarts at 1.
REQ-028 Scenario: N=3, run 9 edges from reset -> out follows 1,3,2,6,7,5,4,0,1, with wrap pulsing once.
